// File: rtl/zbuf_pkg.sv
// Shared Z-buffer types and constants: clear-engine state encoding, far-plane
// depth and the coordinate/address width helpers used across the datapath.
package zbuf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } zclr_state_t;

    // Far-plane depth is all ones; consumers slice the low Z_W bits.
    localparam logic [63:0] Z_FAR = '1;

    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_w(input int h, input int v);
        return coord_w(h * v);
    endfunction

endpackage

// File: rtl/zbuf_xy_scan.sv
// Raster x/y walker with an incrementally maintained row base; emits the linear
// address row_base + x and flags the final pixel of the box.
module zbuf_xy_scan
    import zbuf_pkg::*;
#(
    parameter int H_RES  = 640,
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [X_W-1:0]    xs,
    input  logic [X_W-1:0]    xe,
    input  logic [Y_W-1:0]    ys,
    input  logic [Y_W-1:0]    ye,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [X_W-1:0]    x, xs_q, xe_q;
    logic [Y_W-1:0]    y, ye_q;
    logic [ADDR_W-1:0] row_base;

    assign last = (x == xe_q) && (y == ye_q);
    assign addr = row_base + ADDR_W'(x);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x        <= '0;
            y        <= '0;
            xs_q     <= '0;
            xe_q     <= '0;
            ye_q     <= '0;
            row_base <= '0;
        end else if (load) begin
            x        <= xs;
            y        <= ys;
            xs_q     <= xs;
            xe_q     <= xe;
            ye_q     <= ye;
            // Constant-coefficient product, evaluated only once per sweep.
            row_base <= ADDR_W'(ys) * ADDR_W'(H_RES);
        end else if (step && !last) begin
            if (x < xe_q) begin
                x <= x + 1'b1;
            end else begin
                x        <= xs_q;
                y        <= y + 1'b1;
                row_base <= row_base + ADDR_W'(H_RES);
            end
        end
    end

endmodule

// File: rtl/zbuf_clear_engine.sv
// Frame/region clear sequencer: sweeps the full buffer or a rectangle, writing
// far-plane depth and a background colour through a backpressured write port.
module zbuf_clear_engine
    import zbuf_pkg::*;
#(
    parameter  int H_RES  = 640,
    parameter  int V_RES  = 480,
    parameter  int Z_W    = 16,
    parameter  int C_W    = 12,
    localparam int X_W    = coord_w(H_RES),
    localparam int Y_W    = coord_w(V_RES),
    localparam int ADDR_W = addr_w(H_RES, V_RES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rect_en,
    input  logic [X_W-1:0]    x0,
    input  logic [X_W-1:0]    x1,
    input  logic [Y_W-1:0]    y0,
    input  logic [Y_W-1:0]    y1,
    input  logic [C_W-1:0]    clr_color,
    input  logic              abort,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [Z_W-1:0]    wr_z,
    output logic [C_W-1:0]    wr_color,
    output logic              busy,
    output logic              done,
    output logic              err
);

    zclr_state_t    state;
    logic           rect_bad, load, step, last;
    logic [X_W-1:0] xs, xe;
    logic [Y_W-1:0] ys, ye;

    assign rect_bad = rect_en && ((x0 > x1) || (y0 > y1) ||
                                  ({1'b0, x1} >= (X_W+1)'(H_RES)) ||
                                  ({1'b0, y1} >= (Y_W+1)'(V_RES)));
    assign load = (state == IDLE) && start && !rect_bad;
    assign step = (state == RUN) && wr_en && wr_ready;

    assign xs = rect_en ? x0 : '0;
    assign xe = rect_en ? x1 : X_W'(H_RES - 1);
    assign ys = rect_en ? y0 : '0;
    assign ye = rect_en ? y1 : Y_W'(V_RES - 1);

    assign wr_z = Z_FAR[Z_W-1:0];

    zbuf_xy_scan #(
        .H_RES (H_RES),
        .X_W   (X_W),
        .Y_W   (Y_W),
        .ADDR_W(ADDR_W)
    ) u_scan (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .xs   (xs),
        .xe   (xe),
        .ys   (ys),
        .ye   (ye),
        .addr (wr_addr),
        .last (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wr_color <= '0;
        end else begin
            err  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && rect_bad) begin
                        err <= 1'b1;
                    end else if (start) begin
                        wr_color <= clr_color;
                        wr_en    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        wr_en <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (wr_ready && last) begin
                        wr_en <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    wr_en <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zbuf_clear_engine.sv
// Randomized self-checking bench for zbuf_clear_engine against a queue-based
// model of the expected raster address list.
module tb_zbuf_clear_engine;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int ZW = 16;
    localparam int CW = 12;
    localparam int XW = $clog2(H);
    localparam int YW = $clog2(V);
    localparam int AW = $clog2(H * V);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          rect_en = 1'b0;
    logic          abort = 1'b0;
    logic          wr_ready = 1'b0;
    logic [XW-1:0] x0 = '0, x1 = '0;
    logic [YW-1:0] y0 = '0, y1 = '0;
    logic [CW-1:0] clr_color = '0;
    logic          wr_en, busy, done, err;
    logic [AW-1:0] wr_addr;
    logic [ZW-1:0] wr_z;
    logic [CW-1:0] wr_color;

    int checks = 0;
    int fails  = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    zbuf_clear_engine #(
        .H_RES(H),
        .V_RES(V),
        .Z_W  (ZW),
        .C_W  (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rect_en  (rect_en),
        .x0       (x0),
        .x1       (x1),
        .y0       (y0),
        .y1       (y1),
        .clr_color(clr_color),
        .abort    (abort),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_z     (wr_z),
        .wr_color (wr_color),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit rect_ok(input bit re, input int ax0, input int ax1,
                                   input int ay0, input int ay1);
        return !re || (ax0 <= ax1 && ay0 <= ay1 && ax1 < H && ay1 < V);
    endfunction

    task automatic build(input bit re, input int ax0, input int ax1, input int ay0, input int ay1);
        int xs, xe, ys, ye;
        exp_q.delete();
        if (!rect_ok(re, ax0, ax1, ay0, ay1)) return;
        xs = re ? ax0 : 0;
        xe = re ? ax1 : H - 1;
        ys = re ? ay0 : 0;
        ye = re ? ay1 : V - 1;
        for (int yy = ys; yy <= ye; yy++)
            for (int xx = xs; xx <= xe; xx++)
                exp_q.push_back(yy * H + xx);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_busy"},  32'(busy),  0);
        check({tag, "_done"},  32'(done),  0);
    endtask

    // mode: 0 ready always high, 1 toggling 1/0, 2 random
    task automatic run(input string tag, input bit re, input int ax0, input int ax1,
                       input int ay0, input int ay1, input logic [CW-1:0] col,
                       input int mode, input int abort_at, input int rst_at, input bit poke);
        int  cyc = 0, acc = 0, stalls = 0, total;
        bit  tog = 1'b1, abort_issued = 1'b0, aborted = 1'b0;
        build(re, ax0, ax1, ay0, ay1);
        total = exp_q.size();
        @(posedge clk); #1;
        start = 1'b1; rect_en = re; clr_color = col;
        x0 = XW'(ax0); x1 = XW'(ax1); y0 = YW'(ay0); y1 = YW'(ay1);
        @(posedge clk); #1;
        start = 1'b0;
        wr_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!rect_ok(re, ax0, ax1, ay0, ay1)) begin
            @(negedge clk);
            check({tag, "_err"}, 32'(err), 1);
            check_idle_outputs(tag);
            @(negedge clk);
            check({tag, "_err_once"}, 32'(err), 0);
            check_idle_outputs({tag, "_after"});
            return;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > 600) begin
                check({tag, "_timeout"}, 1, 0);
                break;
            end
            if (aborted) begin
                check_idle_outputs({tag, "_abort"});
                repeat (3) @(negedge clk);
                check({tag, "_abort_nodone"}, 32'(done), 0);
                break;
            end
            if (exp_q.size() == 0) begin
                check({tag, "_done"}, 32'(done), 1);
                check({tag, "_done_busy"}, 32'(busy), 0);
                check({tag, "_done_wr_en"}, 32'(wr_en), 0);
                check({tag, "_done_cycle"}, 32'(cyc), 32'(total + stalls + 1));
                @(negedge clk);
                check({tag, "_done_once"}, 32'(done), 0);
                break;
            end
            check({tag, "_wr_en"}, 32'(wr_en), 1);
            check({tag, "_busy"}, 32'(busy), 1);
            check({tag, "_addr"}, 32'(wr_addr), 32'(exp_q[0]));
            check({tag, "_z"}, 32'(wr_z), 32'hFFFF);
            check({tag, "_color"}, 32'(wr_color), 32'(col));
            check({tag, "_nodone"}, 32'(done), 0);
            if (wr_ready) begin
                void'(exp_q.pop_front());
                acc++;
            end else begin
                stalls++;
            end
            if (abort) aborted = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            if (rst_at >= 0 && acc == rst_at) begin
                rst = 1'b0;
                #1;
                check_idle_outputs({tag, "_rst"});
                check({tag, "_rst_err"}, 32'(err), 0);
                check({tag, "_rst_addr"}, 32'(wr_addr), 0);
                check({tag, "_rst_color"}, 32'(wr_color), 0);
                check({tag, "_rst_z"}, 32'(wr_z), 32'hFFFF);
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    check_idle_outputs({tag, "_noresume"});
                end
                break;
            end
            if (abort_at >= 0 && acc == abort_at && !abort_issued) begin
                abort = 1'b1;
                abort_issued = 1'b1;
            end
            if (poke && acc == 3) begin
                start = 1'b1;
                rect_en = 1'b1;
                x0 = XW'($urandom); x1 = XW'($urandom);
                y0 = YW'($urandom); y1 = YW'($urandom);
                clr_color = CW'($urandom);
            end
            case (mode)
                0:       wr_ready = 1'b1;
                1:       begin tog = ~tog; wr_ready = tog; end
                default: wr_ready = 1'($urandom_range(0, 1));
            endcase
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int rx0, rx1, ry0, ry1;
        #1;
        check_idle_outputs("reset");
        check("reset_err", 32'(err), 0);
        check("reset_addr", 32'(wr_addr), 0);
        check("reset_color", 32'(wr_color), 0);
        check("reset_z", 32'(wr_z), 32'hFFFF);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        run("full",    1'b0, 0, 0, 0, 0, 12'hABC, 0, -1, -1, 1'b0);
        run("rect",    1'b1, 2, 4, 1, 2, 12'h123, 0, -1, -1, 1'b0);
        run("pixel",   1'b1, 7, 7, 3, 3, 12'h456, 0, -1, -1, 1'b0);
        run("stall",   1'b0, 0, 0, 0, 0, 12'h789, 1, -1, -1, 1'b0);
        run("bad_x",   1'b1, 5, 3, 0, 1, 12'h111, 0, -1, -1, 1'b0);
        // x1=8 wraps to 0 in the 3-bit coordinate field, so it fails ordering
        run("bad_x8",  1'b1, 1, 8, 0, 1, 12'h222, 0, -1, -1, 1'b0);
        run("bad_y",   1'b1, 0, 1, 3, 1, 12'h333, 0, -1, -1, 1'b0);
        run("abort",   1'b0, 0, 0, 0, 0, 12'h444, 0,  5, -1, 1'b0);
        run("post_ab", 1'b0, 0, 0, 0, 0, 12'h555, 0, -1, -1, 1'b0);
        run("rst_mid", 1'b0, 0, 0, 0, 0, 12'h666, 0, -1, 10, 1'b1);
        run("post_rs", 1'b0, 0, 0, 0, 0, 12'h777, 2, -1, -1, 1'b1);

        for (int i = 0; i < 20; i++) begin
            rx0 = $urandom_range(0, H - 1);
            rx1 = $urandom_range(0, H - 1);
            ry0 = $urandom_range(0, V - 1);
            ry1 = $urandom_range(0, V - 1);
            run("rand", 1'($urandom_range(0, 1)), rx0, rx1, ry0, ry1,
                CW'($urandom), 2, -1, -1, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/zbuf_clear_engine.md
# zbuf_clear_engine

Parametrised frame/region clear sequencer for the Z-buffer datapath. On a start request it sweeps either the whole H_RES×V_RES buffer or a caller-supplied rectangle, writing far-plane depth and a background colour to the shared Z/colour RAM write port. It supports backpressure and abort. It sits between the top-level request logic (key/req decode) and the RAM arbiter, ahead of the triangle rasterizer.

## Interface
Parameters:
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- Z_W, 16, depth word width
- C_W, 12, colour word width
- X_W / Y_W, $clog2(H_RES) / $clog2(V_RES), coordinate widths (derived localparams)
- ADDR_W, $clog2(H_RES*V_RES), RAM address width (derived localparam)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request, sampled only in IDLE
- rect_en  in  1  1 = clear rectangle x0..x1, y0..y1; 0 = full frame
- x0, x1  in  X_W  inclusive column bounds, sampled with start
- y0, y1  in  Y_W  inclusive line bounds, sampled with start
- clr_color  in  C_W  background colour, sampled with start
- abort  in  1  cancel the sweep in progress
- wr_en  out  1  write request to the RAM arbiter
- wr_ready  in  1  arbiter accepts the write this cycle
- wr_addr  out  ADDR_W  linear address y*H_RES + x
- wr_z  out  Z_W  always Z_FAR (all ones)
- wr_color  out  C_W  latched clr_color
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on normal completion
- err  out  1  one-cycle pulse when a rectangle is rejected

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - If rect_en=1 and (x0>x1, y0>y1, x1≥H_RES or y1≥V_RES): pulse err next cycle, stay in IDLE, no writes.
  - Otherwise latch bounds and colour. Full-frame mode uses bounds 0..H_RES-1, 0..V_RES-1. Set x=xs, y=ys, row_base=ys*H_RES, go to RUN.
- RUN:
  - wr_en=1, wr_addr=row_base+x.
  - Advance only on wr_en&&wr_ready. If x<xe: x+1. Else x=xs, y+1, row_base+=H_RES.
  - The accept on (xe,ye) moves the FSM to DONE.
- DONE: done=1 for one cycle, then IDLE.
- abort=1 in RUN: go to IDLE next cycle, no done, no err. A write accepted in the same cycle as abort counts as a completed write. abort has no effect in IDLE or DONE.
- start while busy or in DONE is ignored.
- Address arithmetic is incremental: one adder per counter, no multiplier. row_base is ADDR_W wide and never exceeds (V_RES-1)*H_RES.
- Scan order is raster: x fastest, y increasing.

## Timing
- Reset (async, rst=0): state IDLE; wr_en, busy, done, err = 0; wr_addr, wr_color = 0; wr_z = Z_FAR.
- Start accepted at edge N: busy=1 and wr_en=1 with the first address from cycle N+1.
- Throughput is 1 pixel per cycle while wr_ready=1. A rectangle of P pixels with wr_ready held high gives done in cycle N+P+1.
- wr_ready=0: wr_addr, wr_color and wr_en held stable. No skipped or duplicated address.
- err: asserted in cycle N+1 for exactly one cycle.
- rst asserted mid-RUN: outputs drop immediately, no done. The sweep does not resume on reset release.
- All outputs registered or decoded from registered state only. No combinational path from wr_ready to wr_en.

## Structure
- Shared zbuf_pkg holds:
  - state enum zclr_state_t {IDLE, RUN, DONE}
  - Z_FAR constant
  - address and coordinate width helper functions used by the rasterizer and RAM wrapper
- One natural sub-module: zbuf_xy_scan. It holds the x/y/row_base counters with a step input and a last output, and is reusable by the rasterizer bounding-box walk.
- The FSM stays in zbuf_clear_engine.

## Test plan
Bench parameters: H_RES=8, V_RES=4, C_W=12, Z_W=16.
- Full clear, rect_en=0, clr_color=12'hABC, wr_ready=1: 32 writes, addr 0..31 in order, wr_z=16'hFFFF, done pulses exactly 33 cycles after the start edge.
- Rectangle x0=2, x1=4, y0=1, y1=2: addresses 10,11,12,18,19,20 in order, then one done pulse. Single-pixel x0=x1=7, y0=y1=3: one write to addr 31.
- Backpressure, wr_ready toggling 1,0,1,0 during a full clear: each address held across stall cycles, 32 distinct accepted writes, no gaps.
- Invalid rectangle x0=5, x1=3: err=1 for one cycle, wr_en never asserted, busy=0. x1=8 is rejected the same way.
- abort after 5 accepted writes: busy falls next cycle, no done. A following start performs a clean full sweep from addr 0.
- rst=0 at write 10, then release: all outputs 0 at once, FSM in IDLE. A start pulse during RUN has no effect on the address sequence.
